regfile_wb_ctrl: RTL and testbench

Parametrised successor to the register-file address/write-enable control. Decodes FD-stage read addresses and arbitrates register-file writeback between the in-order MW stage and the multi-cycle mult/div unit. A small pending queue holds deferred mult/div results, so a conflict never drops a write. A busy scoreboard stalls FD on hazards against outstanding mult/div destinations.

---
 rtl/regfile_wb_ctrl_pkg.sv | 72 +++++++
 rtl/wb_pend_fifo.sv | 79 +++++++
 rtl/regfile_wb_ctrl.sv | 164 ++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_pkg : opcodes, instruction field helpers and types  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_wb_ctrl_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RD_MSB = 26;
  localparam int RD_LSB = 22;
  localparam int RS_MSB = 21;
  localparam int RS_LSB = 17;
  localparam int RT_MSB = 16;
  localparam int RT_LSB = 12;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_MW     = 2'd1,
    SRC_DRAIN  = 2'd2,
    SRC_DIRECT = 2'd3
  } wb_src_e;

  function automatic logic [4:0] ir_op(input logic [31:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [4:0] ir_rd(input logic [31:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] ir_rs(input logic [31:0] ir);
    return ir[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] ir_rt(input logic [31:0] ir);
    return ir[RT_MSB:RT_LSB];
  endfunction

  function automatic logic is_mw_write(input logic [4:0] op);
    return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_JAL);
  endfunction

  function automatic logic reads_rs(input logic [4:0] op);
    return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)  || (op == OP_BNE)  || (op == OP_BLT);
  endfunction

  function automatic logic reads_rt(input logic [4:0] op);
    return (op == OP_ALU);
  endfunction

  function automatic logic reads_rd(input logic [4:0] op);
    return (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
  endfunction

  function automatic logic writes_rd(input logic [4:0] op);
    return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_pend_fifo.sv
// ---------------------------------------------------------------------------
// wb_pend_fifo : small FIFO for deferred mult/div results, push+pop allowed when full  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module wb_pend_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // A pop in the same cycle frees the slot that a push into a full FIFO needs.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl : read decode, MW vs mult/div writeback arbitration, busy scoreboard  (rev 1.0)
// Optional: MD_SB_BYPASS_EN masks a busy bit cleared this cycle out of fd_stall.
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int PEND_DEPTH = 2,
  parameter int LINK_REG   = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       fd_ir,
  input  logic [31:0]       mw_ir,
  input  logic [DATA_W-1:0] mw_data,
  input  logic              md_issue,
  input  logic [REG_AW-1:0] md_issue_rd,
  input  logic              md_valid,
  input  logic [REG_AW-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic [REG_AW-1:0] read_a,
  output logic [REG_AW-1:0] read_b,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fd_stall
);

  localparam int                NREG      = 2 ** REG_AW;
  localparam int                ENTRY_W   = REG_AW + DATA_W;
  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);
  localparam logic [NREG-1:0]   ONE_HOT0  = NREG'(1);

  logic [4:0]        fd_op;
  logic [4:0]        mw_op;
  logic [REG_AW-1:0] fd_rd, fd_rs, fd_rt;
  logic [REG_AW-1:0] mw_addr;
  logic              mw_we;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

  wb_src_e           wb_src;
  logic              drain, direct, accept, md_wr;
  logic [REG_AW-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [NREG-1:0]   set_vec, clr_vec, busy_view;

  assign fd_op = ir_op(fd_ir);
  assign fd_rd = REG_AW'(ir_rd(fd_ir));
  assign fd_rs = REG_AW'(ir_rs(fd_ir));
  assign fd_rt = REG_AW'(ir_rt(fd_ir));

  assign mw_op   = ir_op(mw_ir);
  assign mw_we   = is_mw_write(mw_op);
  assign mw_addr = (mw_op == OP_JAL) ? LINK_ADDR : REG_AW'(ir_rd(mw_ir));

  always_comb begin
    read_a = fd_rs;
    read_b = fd_rt;
    case (fd_op)
      OP_BNE, OP_BLT, OP_JR: begin
        read_a = fd_rd;
        read_b = fd_rs;
      end
      OP_SW, OP_LW: begin
        read_a = fd_rs;
        read_b = fd_rd;
      end
      default: ;
    endcase
  end

  // MW owns the port whenever it writes; the queue then has priority over a fresh result.
  always_comb begin
    drain      = !mw_we && !fifo_empty;
    direct     = !mw_we && fifo_empty && md_valid;
    md_ready   = !reset && (!fifo_full || drain);
    accept     = md_valid && md_ready;
    fifo_push  = accept && !direct;
    fifo_pop   = drain;
    fifo_wdata = {md_rd, md_data};

    wb_src = SRC_NONE;
    if (mw_we)       wb_src = SRC_MW;
    else if (drain)  wb_src = SRC_DRAIN;
    else if (direct) wb_src = SRC_DIRECT;

    sel_addr = '0;
    sel_data = '0;
    md_wr    = 1'b0;
    case (wb_src)
      SRC_MW: begin
        sel_addr = mw_addr;
        sel_data = mw_data;
      end
      SRC_DRAIN: begin
        sel_addr = fifo_rdata[ENTRY_W-1:DATA_W];
        sel_data = fifo_rdata[DATA_W-1:0];
        md_wr    = 1'b1;
      end
      SRC_DIRECT: begin
        sel_addr = md_rd;
        sel_data = md_data;
        md_wr    = 1'b1;
      end
      default: ;
    endcase

    wb_en   = !reset && (wb_src != SRC_NONE) && (sel_addr != '0);
    wb_addr = sel_addr;
    wb_data = sel_data;
  end

  wb_pend_fifo #(
    .DEPTH (PEND_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_pend (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A register issued and retired in the same cycle stays busy: the new op is still in flight.
  always_comb begin
    set_vec = (md_issue && (md_issue_rd != '0)) ? (ONE_HOT0 << md_issue_rd) : '0;
    clr_vec = md_wr ? (ONE_HOT0 << sel_addr) : '0;
    busy_d  = (busy_q & ~clr_vec) | set_vec;
`ifdef MD_SB_BYPASS_EN
    busy_view = busy_q & ~(clr_vec & ~set_vec);
`else
    busy_view = busy_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    fd_stall = 1'b0;
    if (reads_rs(fd_op)  && busy_view[fd_rs]) fd_stall = 1'b1;
    if (reads_rt(fd_op)  && busy_view[fd_rt]) fd_stall = 1'b1;
    if (reads_rd(fd_op)  && busy_view[fd_rd]) fd_stall = 1'b1;
    if (writes_rd(fd_op) && busy_view[fd_rd]) fd_stall = 1'b1;
    if ((fd_op == OP_JAL) && busy_view[LINK_ADDR]) fd_stall = 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl : randomized + directed bench against a queue-based reference model  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_ctrl;

  localparam int DEPTH = 2;
`ifdef MD_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fd_ir = '0;
  logic [31:0] mw_ir = '0;
  logic [31:0] mw_data = '0;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic [4:0]  read_a, read_b;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        fd_stall;

  int total = 0;
  int bad   = 0;

  bit [4:0]  mq_rd[$];
  bit [31:0] mq_data[$];
  bit [31:0] mbusy = '0;
  bit        last_acc;

  regfile_wb_ctrl #(.DATA_W(32), .REG_AW(5), .PEND_DEPTH(DEPTH), .LINK_REG(31)) dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .mw_ir(mw_ir), .mw_data(mw_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd), .md_valid(md_valid), .md_rd(md_rd),
    .md_data(md_data), .md_ready(md_ready), .read_a(read_a), .read_b(read_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .fd_stall(fd_stall)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = op[4:0];
    r[26:22] = rd[4:0];
    r[21:17] = rs[4:0];
    r[16:12] = rt[4:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // One cycle: inputs already driven after a negedge; compare outputs to the model, then advance it.
  task automatic step();
    int       op, frd, frs, frt;
    bit       mw_w, drain, direct, rdy, e_en, md_w;
    bit [4:0] e_addr, ea, eb;
    bit [31:0] e_data, view;
    bit       e_stall;
    int       srcs[$];
    #1;
    op = int'(mw_ir[31:27]);
    mw_w   = (op == 0) || (op == 5) || (op == 8) || (op == 3);
    drain  = !mw_w && (mq_rd.size() > 0);
    rdy    = !reset && ((mq_rd.size() < DEPTH) || drain);
    direct = !mw_w && (mq_rd.size() == 0) && md_valid;
    e_en = 0; md_w = 0; e_addr = '0; e_data = '0;
    if (mw_w) begin
      e_en = 1; e_addr = (op == 3) ? 5'd31 : mw_ir[26:22]; e_data = mw_data;
    end else if (drain) begin
      e_en = 1; md_w = 1; e_addr = mq_rd[0]; e_data = mq_data[0];
    end else if (direct) begin
      e_en = 1; md_w = 1; e_addr = md_rd; e_data = md_data;
    end
    if (e_addr == 0 || reset) e_en = 0;
    chk("wb_en", {31'd0, wb_en}, {31'd0, e_en});
    chk("md_ready", {31'd0, md_ready}, {31'd0, rdy});
    if (e_en) begin
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, e_addr});
      chk("wb_data", wb_data, e_data);
    end

    op  = int'(fd_ir[31:27]);
    frd = int'(fd_ir[26:22]); frs = int'(fd_ir[21:17]); frt = int'(fd_ir[16:12]);
    case (op)
      2, 6, 4: begin ea = frd[4:0]; eb = frs[4:0]; end
      7, 8:    begin ea = frs[4:0]; eb = frd[4:0]; end
      default: begin ea = frs[4:0]; eb = frt[4:0]; end
    endcase
    chk("read_a", {27'd0, read_a}, {27'd0, ea});
    chk("read_b", {27'd0, read_b}, {27'd0, eb});

    if (!reset) begin
      case (op)
        0:       srcs = '{frs, frt, frd};
        5, 8:    srcs = '{frs, frd};
        7, 2, 6: srcs = '{frd, frs};
        4:       srcs = '{frd};
        3:       srcs = '{31};
        default: srcs = '{};
      endcase
      view = mbusy;
      if (BYP && md_w && !(md_issue && md_issue_rd == e_addr)) view[e_addr] = 1'b0;
      e_stall = 0;
      foreach (srcs[i]) if (view[srcs[i]]) e_stall = 1;
      chk("fd_stall", {31'd0, fd_stall}, {31'd0, e_stall});
    end

    @(posedge clock);
    last_acc = md_valid && rdy;
    if (reset) begin
      mq_rd.delete(); mq_data.delete(); mbusy = '0;
    end else begin
      if (drain) begin void'(mq_rd.pop_front()); void'(mq_data.pop_front()); end
      if (md_valid && rdy && !direct) begin mq_rd.push_back(md_rd); mq_data.push_back(md_data); end
      if (md_w) mbusy[e_addr] = 1'b0;
      if (md_issue && md_issue_rd != 0) mbusy[md_issue_rd] = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    mw_ir = mk(7, 1, 2, 3); fd_ir = mk(9, 0, 0, 0);
    md_valid = 0; md_issue = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); mw_ir = mk(3, 0, 0, 0); md_valid = 1; md_rd = 5;
    #1;
    chk("reset_md_ready", {31'd0, md_ready}, 32'd0);
    chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
    step(); step();
    reset = 0; idle_inputs(); fd_ir = mk(0, 1, 2, 3);
    #1;
    chk("post_reset_ready", {31'd0, md_ready}, 32'd1);
    chk("post_reset_stall", {31'd0, fd_stall}, 32'd0);
    step();
  endtask

  task automatic test_decode();
    idle_inputs();
    fd_ir = mk(2, 3, 4, 0); #1;
    chk("dec_bne_a", {27'd0, read_a}, 32'd3); chk("dec_bne_b", {27'd0, read_b}, 32'd4);
    step();
    fd_ir = mk(7, 5, 6, 0); #1;
    chk("dec_sw_a", {27'd0, read_a}, 32'd6); chk("dec_sw_b", {27'd0, read_b}, 32'd5);
    step();
    fd_ir = mk(0, 9, 1, 2); #1;
    chk("dec_alu_a", {27'd0, read_a}, 32'd1); chk("dec_alu_b", {27'd0, read_b}, 32'd2);
    step();
    for (int i = 0; i < 20; i++) begin
      fd_ir = mk($urandom_range(0, 9), $urandom, $urandom, $urandom);
      step();
    end
  endtask

  task automatic test_mw_write();
    idle_inputs();
    mw_ir = mk(3, 7, 0, 0); mw_data = $urandom; #1;
    chk("jal_en", {31'd0, wb_en}, 32'd1);
    chk("jal_addr", {27'd0, wb_addr}, 32'd31);
    chk("jal_data", wb_data, mw_data);
    step();
    mw_ir = mk(0, 0, 1, 2); #1;
    chk("r0_suppress", {31'd0, wb_en}, 32'd0);
    step();
  endtask

  task automatic test_conflict();
    idle_inputs();
    mw_ir = mk(0, 4, 1, 2); mw_data = 32'h1111_2222;
    md_valid = 1; md_rd = 9; md_data = 32'h0000_ABCD; #1;
    chk("conf_mw_addr", {27'd0, wb_addr}, 32'd4);
    chk("conf_ready", {31'd0, md_ready}, 32'd1);
    step();
    md_valid = 0; mw_ir = mk(7, 1, 2, 3); #1;
    chk("conf_q_addr", {27'd0, wb_addr}, 32'd9);
    chk("conf_q_data", wb_data, 32'h0000_ABCD);
    step();
  endtask

  task automatic test_queue_full();
    int k = 0;
    bit exp_rdy[4] = '{1, 1, 0, 0};
    idle_inputs();
    md_valid = 1;
    for (int c = 0; c < 4; c++) begin
      mw_ir = mk(0, 4, 1, 2); mw_data = $urandom;
      md_rd = 5'(10 + k); md_data = 32'(k + 100); #1;
      chk("qfull_ready", {31'd0, md_ready}, {31'd0, exp_rdy[c]});
      step();
      if (last_acc) k++;
    end
    mw_ir = mk(7, 1, 2, 3); md_rd = 5'(10 + k); md_data = 32'(k + 100); #1;
    chk("qdrain_ready", {31'd0, md_ready}, 32'd1);
    chk("qdrain_addr", {27'd0, wb_addr}, 32'd10);
    step();
    md_valid = 0;
  endtask

  task automatic test_reset_mid();
    mw_ir = mk(0, 4, 1, 2); md_issue = 1; md_issue_rd = 7;
    step();
    md_issue = 0; reset = 1;
    step();
    reset = 0; idle_inputs(); fd_ir = mk(0, 3, 7, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_mid_wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst_mid_ready", {31'd0, md_ready}, 32'd1);
      chk("rst_mid_stall", {31'd0, fd_stall}, 32'd0);
      step();
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    md_issue = 1; md_issue_rd = 7;
    step();
    md_issue = 0; fd_ir = mk(0, 3, 7, 1);
    for (int c = 0; c < 2; c++) begin
      #1; chk("sb_stall_hold", {31'd0, fd_stall}, 32'd1);
      step();
    end
    md_valid = 1; md_rd = 7; md_data = 32'hDEAD_0007; #1;
    chk("sb_write_en", {31'd0, wb_en}, 32'd1);
    chk("sb_write_cycle_stall", {31'd0, fd_stall}, {31'd0, !BYP});
    step();
    md_valid = 0; #1;
    chk("sb_after_stall", {31'd0, fd_stall}, 32'd0);
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      fd_ir       = mk($urandom_range(0, 9), $urandom, $urandom, $urandom);
      mw_ir       = ($urandom_range(0, 9) < 6) ? mk(0, $urandom, 0, 0) : mk($urandom_range(0, 9), $urandom, 0, 0);
      mw_data     = $urandom;
      md_issue    = ($urandom_range(0, 9) < 3);
      md_issue_rd = 5'($urandom);
      md_valid    = ($urandom_range(0, 9) < 5);
      md_rd       = 5'($urandom_range(0, 7));
      md_data     = $urandom;
      step();
    end
    reset = 0;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_decode();
    test_mw_write();
    test_conflict();
    test_queue_full();
    test_reset_mid();
    test_scoreboard();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
